// File: rtl/id_ex_if.sv
// Bundle of signals between the decode stage, the ID/EX register and the
// execute stage. The ID/EX register uses the slave modport; the decode side
// (and the bench) uses the master modport.
interface id_ex_if #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
);
   logic              stall_i;
   logic              flush_i;
   logic [REG_W-1:0]  IFID_RegRS_i;
   logic [REG_W-1:0]  IFID_RegRT_i;
   logic [REG_W-1:0]  IFID_RegRD_i;
   logic [DATA_W-1:0] RSdata_i;
   logic [DATA_W-1:0] RTdata_i;
   logic [DATA_W-1:0] Imm_i;
   logic              RegWrite_i;
   logic              MemtoReg_i;
   logic              MemRead_i;
   logic              MemWrite_i;
   logic              ALUSrc_i;
   logic              RegDst_i;
   logic [1:0]        ALUOp_i;

   logic [REG_W-1:0]  IDEX_RegRS_o;
   logic [REG_W-1:0]  IDEX_RegRT_o;
   logic [REG_W-1:0]  IDEX_RegRD_o;
   logic [DATA_W-1:0] IDEX_RSdata_o;
   logic [DATA_W-1:0] IDEX_RTdata_o;
   logic [DATA_W-1:0] IDEX_Imm_o;
   logic              IDEX_RegWrite_o;
   logic              IDEX_MemtoReg_o;
   logic              IDEX_MemRead_o;
   logic              IDEX_MemWrite_o;
   logic              IDEX_ALUSrc_o;
   logic              IDEX_RegDst_o;
   logic [1:0]        IDEX_ALUOp_o;
   logic              hazard_o;
   logic              PCWrite_o;
   logic              IFIDWrite_o;
   logic [CNT_W-1:0]  bubble_cnt_o;

   modport master (
      output stall_i, flush_i, IFID_RegRS_i, IFID_RegRT_i, IFID_RegRD_i,
             RSdata_i, RTdata_i, Imm_i, RegWrite_i, MemtoReg_i, MemRead_i,
             MemWrite_i, ALUSrc_i, RegDst_i, ALUOp_i,
      input  IDEX_RegRS_o, IDEX_RegRT_o, IDEX_RegRD_o, IDEX_RSdata_o,
             IDEX_RTdata_o, IDEX_Imm_o, IDEX_RegWrite_o, IDEX_MemtoReg_o,
             IDEX_MemRead_o, IDEX_MemWrite_o, IDEX_ALUSrc_o, IDEX_RegDst_o,
             IDEX_ALUOp_o, hazard_o, PCWrite_o, IFIDWrite_o, bubble_cnt_o
   );

   modport slave (
      input  stall_i, flush_i, IFID_RegRS_i, IFID_RegRT_i, IFID_RegRD_i,
             RSdata_i, RTdata_i, Imm_i, RegWrite_i, MemtoReg_i, MemRead_i,
             MemWrite_i, ALUSrc_i, RegDst_i, ALUOp_i,
      output IDEX_RegRS_o, IDEX_RegRT_o, IDEX_RegRD_o, IDEX_RSdata_o,
             IDEX_RTdata_o, IDEX_Imm_o, IDEX_RegWrite_o, IDEX_MemtoReg_o,
             IDEX_MemRead_o, IDEX_MemWrite_o, IDEX_ALUSrc_o, IDEX_RegDst_o,
             IDEX_ALUOp_o, hazard_o, PCWrite_o, IFIDWrite_o, bubble_cnt_o
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS datapath with load-use hazard
// detection, bubble insertion and a saturating debug count of bubbles.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) (
   input logic    clk_i,
   input logic    rst_i,
   id_ex_if.slave bus
);
   // Control vector layout:
   // [7] RegWrite [6] MemtoReg [5] MemRead [4] MemWrite
   // [3] ALUSrc   [2] RegDst   [1:0] ALUOp
   localparam int CTRL_W = 8;
   localparam int MEMREAD_BIT = 5;

   logic [CTRL_W-1:0] ctrl_in_s;
   logic [CTRL_W-1:0] ctrl_d, ctrl_q;
   logic [REG_W-1:0]  rs_d, rs_q;
   logic [REG_W-1:0]  rt_d, rt_q;
   logic [REG_W-1:0]  rd_d, rd_q;
   logic [DATA_W-1:0] rsdata_d, rsdata_q;
   logic [DATA_W-1:0] rtdata_d, rtdata_q;
   logic [DATA_W-1:0] imm_d, imm_q;
   logic [CNT_W-1:0]  cnt_d, cnt_q;
   logic              hazard_s;
   logic              bubble_s;
   logic              freeze_s;

   assign ctrl_in_s = {bus.RegWrite_i, bus.MemtoReg_i, bus.MemRead_i,
                       bus.MemWrite_i, bus.ALUSrc_i, bus.RegDst_i,
                       bus.ALUOp_i};

   // Load-use detection: a load in EX whose target (not $0) is read in ID.
   always_comb begin
      hazard_s = 1'b0;
      if (ctrl_q[MEMREAD_BIT] && (rt_q != {REG_W{1'b0}}) &&
          ((rt_q == bus.IFID_RegRS_i) || (rt_q == bus.IFID_RegRT_i))) begin
         hazard_s = 1'b1;
      end else begin
         hazard_s = 1'b0;
      end
   end

   assign freeze_s = hazard_s | bus.stall_i;
   assign bubble_s = ~bus.stall_i & (hazard_s | bus.flush_i);

   // Next-state selection: hold on stall, bubble on hazard/flush, else load.
   always_comb begin
      ctrl_d   = ctrl_q;
      rs_d     = rs_q;
      rt_d     = rt_q;
      rd_d     = rd_q;
      rsdata_d = rsdata_q;
      rtdata_d = rtdata_q;
      imm_d    = imm_q;
      cnt_d    = cnt_q;
      if (bus.stall_i) begin
         ctrl_d = ctrl_q;
      end else if (bubble_s) begin
         // Register numbers are cleared too, so a bubble can never match
         // in the forwarding unit.
         ctrl_d   = {CTRL_W{1'b0}};
         rs_d     = {REG_W{1'b0}};
         rt_d     = {REG_W{1'b0}};
         rd_d     = {REG_W{1'b0}};
         rsdata_d = bus.RSdata_i;
         rtdata_d = bus.RTdata_i;
         imm_d    = bus.Imm_i;
         if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            cnt_d = cnt_q;
         end
      end else begin
         ctrl_d   = ctrl_in_s;
         rs_d     = bus.IFID_RegRS_i;
         rt_d     = bus.IFID_RegRT_i;
         rd_d     = bus.IFID_RegRD_i;
         rsdata_d = bus.RSdata_i;
         rtdata_d = bus.RTdata_i;
         imm_d    = bus.Imm_i;
      end
   end

   // Pipeline register state with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ctrl_q   <= {CTRL_W{1'b0}};
         rs_q     <= {REG_W{1'b0}};
         rt_q     <= {REG_W{1'b0}};
         rd_q     <= {REG_W{1'b0}};
         rsdata_q <= {DATA_W{1'b0}};
         rtdata_q <= {DATA_W{1'b0}};
         imm_q    <= {DATA_W{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
      end else begin
         ctrl_q   <= ctrl_d;
         rs_q     <= rs_d;
         rt_q     <= rt_d;
         rd_q     <= rd_d;
         rsdata_q <= rsdata_d;
         rtdata_q <= rtdata_d;
         imm_q    <= imm_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.IDEX_RegWrite_o = ctrl_q[7];
   assign bus.IDEX_MemtoReg_o = ctrl_q[6];
   assign bus.IDEX_MemRead_o  = ctrl_q[5];
   assign bus.IDEX_MemWrite_o = ctrl_q[4];
   assign bus.IDEX_ALUSrc_o   = ctrl_q[3];
   assign bus.IDEX_RegDst_o   = ctrl_q[2];
   assign bus.IDEX_ALUOp_o    = ctrl_q[1:0];
   assign bus.IDEX_RegRS_o    = rs_q;
   assign bus.IDEX_RegRT_o    = rt_q;
   assign bus.IDEX_RegRD_o    = rd_q;
   assign bus.IDEX_RSdata_o   = rsdata_q;
   assign bus.IDEX_RTdata_o   = rtdata_q;
   assign bus.IDEX_Imm_o      = imm_q;
   assign bus.bubble_cnt_o    = cnt_q;
   assign bus.hazard_o        = hazard_s;
   assign bus.PCWrite_o       = ~freeze_s;
   assign bus.IFIDWrite_o     = ~freeze_s;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, table-driven bench for id_ex_stage plus hand-written reset and
// counter-saturation sequences (saturation uses a CNT_W=4 instance).
module tb_id_ex_stage;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   id_ex_if #(.DATA_W(32), .REG_W(5), .CNT_W(16)) bus  ();
   id_ex_if #(.DATA_W(32), .REG_W(5), .CNT_W(4))  bus4 ();

   id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(16)) dut (
      .clk_i(clk), .rst_i(rst_n), .bus(bus.slave));
   id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(4)) dut4 (
      .clk_i(clk), .rst_i(rst_n), .bus(bus4.slave));

   // ctrl layout: {RegWrite,MemtoReg,MemRead,MemWrite,ALUSrc,RegDst,ALUOp}
   typedef struct {
      logic        stall;
      logic        flush;
      logic [7:0]  ctrl;
      logic [4:0]  rs, rt, rd;
      logic [31:0] rsd;
      logic        e_haz;
      logic [7:0]  e_ctrl;
      logic [4:0]  e_rs, e_rt, e_rd;
      logic [31:0] e_rsd;
      logic        chk_rsd;
      logic        chk_ld;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vecs [19];

   function automatic vec_t mk(input logic st, input logic fl,
         input logic [7:0] c, input logic [4:0] s, input logic [4:0] t,
         input logic [4:0] d, input logic [31:0] sd, input logic eh,
         input logic [7:0] ec, input logic [4:0] es, input logic [4:0] et,
         input logic [4:0] ed, input logic [31:0] esd, input logic cr,
         input logic cl, input logic [15:0] ecnt);
      vec_t v;
      v.stall = st; v.flush = fl; v.ctrl = c; v.rs = s; v.rt = t; v.rd = d;
      v.rsd = sd; v.e_haz = eh; v.e_ctrl = ec; v.e_rs = es; v.e_rt = et;
      v.e_rd = ed; v.e_rsd = esd; v.chk_rsd = cr; v.chk_ld = cl;
      v.e_cnt = ecnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] out_ctrl();
      return {bus.IDEX_RegWrite_o, bus.IDEX_MemtoReg_o, bus.IDEX_MemRead_o,
              bus.IDEX_MemWrite_o, bus.IDEX_ALUSrc_o, bus.IDEX_RegDst_o,
              bus.IDEX_ALUOp_o};
   endfunction

   task automatic drive(input vec_t v);
      bus.stall_i      = v.stall;
      bus.flush_i      = v.flush;
      bus.IFID_RegRS_i = v.rs;
      bus.IFID_RegRT_i = v.rt;
      bus.IFID_RegRD_i = v.rd;
      bus.RSdata_i     = v.rsd;
      bus.RTdata_i     = v.rsd ^ 32'h0F0F_0000;
      bus.Imm_i        = v.rsd + 32'h0000_0001;
      {bus.RegWrite_i, bus.MemtoReg_i, bus.MemRead_i, bus.MemWrite_i,
       bus.ALUSrc_i, bus.RegDst_i, bus.ALUOp_i} = v.ctrl;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctrl"}, {24'h0, out_ctrl()}, 32'h0);
      chk({tag, "_regs"}, {17'h0, bus.IDEX_RegRS_o, bus.IDEX_RegRT_o,
                           bus.IDEX_RegRD_o}, 32'h0);
      chk({tag, "_rsd"}, bus.IDEX_RSdata_o, 32'h0);
      chk({tag, "_rtd"}, bus.IDEX_RTdata_o, 32'h0);
      chk({tag, "_imm"}, bus.IDEX_Imm_o, 32'h0);
      chk({tag, "_cnt"}, {16'h0, bus.bubble_cnt_o}, 32'h0);
      chk({tag, "_cnt4"}, {28'h0, bus4.bubble_cnt_o}, 32'h0);
   endtask

   initial begin
      vec_t z;
      logic e_pcw;
      z = mk(1'b0, 1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 8'h00,
             5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 16'd0);
      drive(z);
      bus4.stall_i = 1'b0; bus4.flush_i = 1'b0;
      bus4.IFID_RegRS_i = 5'd0; bus4.IFID_RegRT_i = 5'd0;
      bus4.IFID_RegRD_i = 5'd0; bus4.RSdata_i = 32'h0;
      bus4.RTdata_i = 32'h0; bus4.Imm_i = 32'h0;
      bus4.RegWrite_i = 1'b0; bus4.MemtoReg_i = 1'b0; bus4.MemRead_i = 1'b0;
      bus4.MemWrite_i = 1'b0; bus4.ALUSrc_i = 1'b0; bus4.RegDst_i = 1'b0;
      bus4.ALUOp_i = 2'b00;

      vecs[0]  = mk(1'b0,1'b0,8'h82,5'd3,5'd4,5'd5,32'h0000_1234, 1'b0,8'h82,5'd3,5'd4,5'd5,32'h0000_1234,1'b1,1'b1,16'd0);
      vecs[1]  = mk(1'b0,1'b0,8'hE8,5'd9,5'd8,5'd0,32'h0000_0100, 1'b0,8'hE8,5'd9,5'd8,5'd0,32'h0000_0100,1'b1,1'b1,16'd0);
      vecs[2]  = mk(1'b0,1'b0,8'h82,5'd8,5'd10,5'd11,32'h0000_AAAA,1'b1,8'h00,5'd0,5'd0,5'd0,32'h0,1'b0,1'b0,16'd1);
      vecs[3]  = mk(1'b0,1'b0,8'h82,5'd8,5'd10,5'd11,32'h0000_AAAA,1'b0,8'h82,5'd8,5'd10,5'd11,32'h0000_AAAA,1'b1,1'b1,16'd1);
      vecs[4]  = mk(1'b0,1'b0,8'hE8,5'd2,5'd0,5'd0,32'h0000_0020, 1'b0,8'hE8,5'd2,5'd0,5'd0,32'h0000_0020,1'b1,1'b1,16'd1);
      vecs[5]  = mk(1'b0,1'b0,8'h82,5'd0,5'd0,5'd6,32'h0000_0033, 1'b0,8'h82,5'd0,5'd0,5'd6,32'h0000_0033,1'b1,1'b1,16'd1);
      vecs[6]  = mk(1'b0,1'b0,8'hE8,5'd1,5'd7,5'd0,32'h0000_0044, 1'b0,8'hE8,5'd1,5'd7,5'd0,32'h0000_0044,1'b1,1'b1,16'd1);
      vecs[7]  = mk(1'b1,1'b0,8'h82,5'd3,5'd7,5'd12,32'h0000_0055,1'b1,8'hE8,5'd1,5'd7,5'd0,32'h0000_0044,1'b1,1'b0,16'd1);
      vecs[8]  = vecs[7];
      vecs[9]  = vecs[7];
      vecs[10] = mk(1'b0,1'b0,8'h82,5'd3,5'd7,5'd12,32'h0000_0055,1'b1,8'h00,5'd0,5'd0,5'd0,32'h0,1'b0,1'b0,16'd2);
      vecs[11] = mk(1'b0,1'b0,8'h82,5'd3,5'd7,5'd12,32'h0000_0055,1'b0,8'h82,5'd3,5'd7,5'd12,32'h0000_0055,1'b1,1'b1,16'd2);
      vecs[12] = mk(1'b0,1'b0,8'hE8,5'd4,5'd5,5'd0,32'h0000_0066, 1'b0,8'hE8,5'd4,5'd5,5'd0,32'h0000_0066,1'b1,1'b1,16'd2);
      vecs[13] = mk(1'b0,1'b1,8'h82,5'd5,5'd6,5'd7,32'h0000_0077, 1'b1,8'h00,5'd0,5'd0,5'd0,32'h0,1'b0,1'b0,16'd3);
      vecs[14] = mk(1'b0,1'b1,8'h82,5'd1,5'd2,5'd3,32'h0000_0088, 1'b0,8'h00,5'd0,5'd0,5'd0,32'h0,1'b0,1'b0,16'd4);
      vecs[15] = mk(1'b0,1'b0,8'h18,5'd6,5'd7,5'd0,32'hDEAD_BEEF, 1'b0,8'h18,5'd6,5'd7,5'd0,32'hDEAD_BEEF,1'b1,1'b1,16'd4);
      vecs[16] = mk(1'b0,1'b0,8'hE8,5'd1,5'd9,5'd0,32'h0000_0099, 1'b0,8'hE8,5'd1,5'd9,5'd0,32'h0000_0099,1'b1,1'b1,16'd4);
      vecs[17] = mk(1'b0,1'b0,8'h82,5'd2,5'd9,5'd3,32'h0000_00AA, 1'b1,8'h00,5'd0,5'd0,5'd0,32'h0,1'b0,1'b0,16'd5);
      vecs[18] = mk(1'b0,1'b0,8'h82,5'd2,5'd9,5'd3,32'h0000_00AA, 1'b0,8'h82,5'd2,5'd9,5'd3,32'h0000_00AA,1'b1,1'b1,16'd5);

      // Reset state held from time zero.
      #1;
      chk_all_zero("reset_init");
      @(negedge clk);
      rst_n = 1'b1;

      // Table: check combinational outputs before the edge, registers after.
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         e_pcw = ~(vecs[i].e_haz | vecs[i].stall);
         chk($sformatf("v%0d_hazard", i), {31'h0, bus.hazard_o}, {31'h0, vecs[i].e_haz});
         chk($sformatf("v%0d_pcwrite", i), {31'h0, bus.PCWrite_o}, {31'h0, e_pcw});
         chk($sformatf("v%0d_ifidwrite", i), {31'h0, bus.IFIDWrite_o}, {31'h0, e_pcw});
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_ctrl", i), {24'h0, out_ctrl()}, {24'h0, vecs[i].e_ctrl});
         chk($sformatf("v%0d_rs", i), {27'h0, bus.IDEX_RegRS_o}, {27'h0, vecs[i].e_rs});
         chk($sformatf("v%0d_rt", i), {27'h0, bus.IDEX_RegRT_o}, {27'h0, vecs[i].e_rt});
         chk($sformatf("v%0d_rd", i), {27'h0, bus.IDEX_RegRD_o}, {27'h0, vecs[i].e_rd});
         chk($sformatf("v%0d_cnt", i), {16'h0, bus.bubble_cnt_o}, {16'h0, vecs[i].e_cnt});
         if (vecs[i].chk_rsd) begin
            chk($sformatf("v%0d_rsdata", i), bus.IDEX_RSdata_o, vecs[i].e_rsd);
         end
         if (vecs[i].chk_ld) begin
            chk($sformatf("v%0d_rtdata", i), bus.IDEX_RTdata_o, vecs[i].rsd ^ 32'h0F0F_0000);
            chk($sformatf("v%0d_imm", i), bus.IDEX_Imm_o, vecs[i].rsd + 32'h0000_0001);
         end
      end

      // Asynchronous reset mid-stall with every input nonzero, between edges.
      @(negedge clk);
      drive(mk(1'b1,1'b1,8'hFF,5'd9,5'd9,5'd9,32'hFFFF_FFFF,1'b0,8'h00,
               5'd0,5'd0,5'd0,32'h0,1'b0,1'b0,16'd0));
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("reset_async");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_stall_hold_cnt", {16'h0, bus.bubble_cnt_o}, 32'h0);
      chk("reset_stall_hold_ctrl", {24'h0, out_ctrl()}, 32'h0);

      // Saturation on the 4-bit counter instance: 20 consecutive flushes.
      @(negedge clk);
      bus4.flush_i = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("sat_cnt4_%0d", k), {28'h0, bus4.bubble_cnt_o},
             (k < 15) ? k : 32'd15);
      end
      @(negedge clk);
      bus4.flush_i = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
